// File: rtl/sram_delay_sequencer_if.sv
// sram_delay_sequencer_if: sample stream and SPI controller signals of the delay-line sequencer
interface sram_delay_sequencer_if #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int FRAME_W = 48
);
  logic               sample_valid;
  logic [DATA_W-1:0]  sample_in;
  logic [ADDR_W-1:0]  delay;
  logic [DATA_W-1:0]  sample_out;
  logic               out_valid;
  logic               busy;
  logic               overrun;
  logic               spi_cs;
  logic [FRAME_W-1:0] spi_tx_data;
  logic [FRAME_W-1:0] spi_rx_data;
  logic               spi_done;
  modport master (
    output sample_valid, sample_in, delay, spi_rx_data, spi_done,
    input  sample_out, out_valid, busy, overrun, spi_cs, spi_tx_data
  );
  modport slave (
    input  sample_valid, sample_in, delay, spi_rx_data, spi_done,
    output sample_out, out_valid, busy, overrun, spi_cs, spi_tx_data
  );
endinterface

// File: rtl/sram_delay_sequencer.sv
// sram_delay_sequencer: per-sample SPI SRAM write-then-read sequencer for a delay line
module sram_delay_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int FRAME_W = 48
) (
  input logic clk,
  input logic nrst,
  sram_delay_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_START, WR_WAIT, RD_SETUP, RD_START, RD_WAIT, RD_CAPTURE
  } state_t;
  state_t state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] dly;
  logic [DATA_W-1:0] smp;
  logic seen_busy;
  logic [ADDR_W-1:0] rd_ptr;
  // wr_ptr has already advanced past the written word when the read frame is built
  assign rd_ptr = wr_ptr - ADDR_W'(1) - dly;
  function automatic logic [23:0] byte_addr(input logic [ADDR_W-1:0] p);
    return 24'({p, 1'b0});
  endfunction
  // Sequencer FSM: write frame, read frame, capture one cycle after the read completes
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      dly             <= '0;
      smp             <= '0;
      seen_busy       <= 1'b0;
      bus.sample_out  <= '0;
      bus.out_valid   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.overrun     <= 1'b0;
      bus.spi_cs      <= 1'b1;
      bus.spi_tx_data <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.overrun   <= bus.sample_valid && state != IDLE;
      case (state)
        IDLE: if (bus.sample_valid) begin
          smp      <= bus.sample_in;
          dly      <= bus.delay;
          bus.busy <= 1'b1;
          state    <= WR_SETUP;
        end
        WR_SETUP: begin
          bus.spi_tx_data <= {8'h02, byte_addr(wr_ptr), smp};
          state           <= WR_START;
        end
        RD_SETUP: begin
          bus.spi_tx_data <= {8'h03, byte_addr(rd_ptr), DATA_W'(0)};
          state           <= RD_START;
        end
        WR_START, RD_START: begin
          bus.spi_cs <= 1'b0;
          seen_busy  <= 1'b0;
          state      <= (state == WR_START) ? WR_WAIT : RD_WAIT;
        end
        WR_WAIT, RD_WAIT: if (seen_busy && bus.spi_done) begin
          bus.spi_cs <= 1'b1;
          if (state == WR_WAIT) wr_ptr <= wr_ptr + ADDR_W'(1);
          state <= (state == WR_WAIT) ? RD_SETUP : RD_CAPTURE;
        end else if (!bus.spi_done) begin
          seen_busy <= 1'b1;
        end
        RD_CAPTURE: begin
          bus.sample_out <= bus.spi_rx_data[DATA_W-1:0];
          bus.out_valid  <= 1'b1;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_delay_sequencer.sv
// tb_sram_delay_sequencer: random and directed checks against a queue-based delay-line model
module tb_sram_delay_sequencer;
  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;
  sram_delay_sequencer_if bus ();
  sram_delay_sequencer dut (.clk(clk), .nrst(nrst), .bus(bus));

  int npass = 0, ntot = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  function automatic logic [15:0] preset(input int a);
    return 16'(a * 7 + 23040);
  endfunction

  // external SRAM contents as seen by the controller model
  logic [15:0] sram [int];
  // SPI controller + SRAM model
  logic [47:0] cf;
  int cw, ck;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.spi_cs === 1'b0) begin
        cf = bus.spi_tx_data;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.spi_done = 1'b0;
        repeat ($urandom_range(3, 8)) @(negedge clk);
        bus.spi_done = 1'b1;
        cw = int'(cf[39:17]);
        if (cf[47:40] == 8'h02) sram[cw] = cf[15:0];
        else begin
          @(negedge clk);
          bus.spi_rx_data = {32'($urandom), sram.exists(cw) ? sram[cw] : preset(cw)};
        end
        ck = 0;
        while (bus.spi_cs === 1'b0 && ck < 100) begin
          @(negedge clk);
          ck++;
        end
      end
    end
  end

  // behavioural model: each accepted sample writes at wp, reads wp-delay, returns that word
  logic [15:0] mdl [int];
  logic [47:0] q_frm[$], obs_frm[$];
  logic [15:0] q_out[$], obs_out[$];
  logic m_busy = 1'b0, exp_ov = 1'b0, prev_cs = 1'b1, fin;
  logic [15:0] m_wp = 16'h0, m_rp;
  logic [47:0] cur_frame = '0;
  int acc_cyc = 0, lowcnt = 0, rises = 0, ov_seen = 0, outv_cnt = 0;

  always @(negedge clk) begin
    if (!nrst) begin
      chk("rst_cs", bus.spi_cs, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_sample_out", bus.sample_out, 0);
      chk("rst_overrun", bus.overrun, 0);
      m_busy = 0; exp_ov = 0; prev_cs = 1; m_wp = 0; rises = 0; lowcnt = 0;
      q_frm.delete(); q_out.delete();
    end else begin
      fin = m_busy && rises == 2 && cyc == acc_cyc + 5 + lowcnt;
      chk("out_valid", bus.out_valid, fin);
      if (bus.out_valid) begin
        outv_cnt++;
        obs_out.push_back(bus.sample_out);
      end
      if (fin) begin
        chk("sample_out", bus.sample_out, q_out.size() != 0 ? q_out.pop_front() : 16'hxxxx);
        m_busy = 0;
      end
      if (bus.overrun) ov_seen++;
      chk("overrun", bus.overrun, exp_ov);
      chk("busy", bus.busy, m_busy);
      if (!m_busy) chk("cs_idle", bus.spi_cs, 1);
      if (bus.spi_cs == 0 && prev_cs == 1) begin
        chk("frame", bus.spi_tx_data, q_frm.size() != 0 ? q_frm.pop_front() : 48'hx);
        obs_frm.push_back(bus.spi_tx_data);
        cur_frame = bus.spi_tx_data;
        if (rises == 0) chk("cs_fall_cycle", 64'(cyc - acc_cyc), 2);
      end
      if (bus.spi_cs == 0) begin
        chk("tx_stable", bus.spi_tx_data, cur_frame);
        lowcnt++;
      end
      if (bus.spi_cs == 1 && prev_cs == 0) rises++;
      prev_cs = bus.spi_cs;
      exp_ov = 0;
      if (bus.sample_valid) begin
        if (m_busy) exp_ov = 1;
        else begin
          m_rp = m_wp - bus.delay;
          q_frm.push_back({8'h02, 24'({m_wp, 1'b0}), bus.sample_in});
          q_frm.push_back({8'h03, 24'({m_rp, 1'b0}), 16'h0});
          mdl[int'(m_wp)] = bus.sample_in;
          q_out.push_back(mdl.exists(int'(m_rp)) ? mdl[int'(m_rp)] : preset(int'(m_rp)));
          m_wp = m_wp + 16'h1;
          m_busy = 1; acc_cyc = cyc + 1; lowcnt = 0; rises = 0;
        end
      end
    end
  end

  task automatic wait_out();
    int k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("out_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] s, input logic [15:0] d, input int ovgap);
    @(posedge clk); #1;
    bus.sample_valid = 1; bus.sample_in = s; bus.delay = d;
    @(posedge clk); #1;
    bus.sample_valid = 0; bus.sample_in = 16'($urandom); bus.delay = 16'($urandom);
    if (ovgap > 0) begin
      repeat (ovgap - 1) @(posedge clk);
      #1 bus.sample_valid = 1;
      @(posedge clk); #1 bus.sample_valid = 0;
    end
    wait_out();
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  int f0, o0, v0, k;
  initial begin
    bus.sample_valid = 0; bus.sample_in = 0; bus.delay = 0;
    bus.spi_done = 1; bus.spi_rx_data = 0;
    #2 nrst = 0;
    repeat (3) @(posedge clk);
    #1 nrst = 1;
    repeat (5) @(negedge clk);
    chk("idle_cs", bus.spi_cs, 1);
    // delay 0 returns the sample just written
    f0 = obs_frm.size(); v0 = outv_cnt;
    send(16'h1234, 0, 0);
    repeat (5) @(negedge clk);
    chk("t1_wr_frame", obs_frm[f0], 48'h02_000000_1234);
    chk("t1_rd_frame", obs_frm[f0+1], 48'h03_000000_0000);
    chk("t1_out", obs_out[obs_out.size()-1], 16'h1234);
    chk("t1_one_pulse", 64'(outv_cnt - v0), 1);
    // ramp with delay 3
    f0 = obs_frm.size(); o0 = obs_out.size();
    for (int n = 0; n < 10; n++) send(16'(n), 3, 0);
    for (int n = 0; n < 10; n++) begin
      chk("ramp_waddr", obs_frm[f0+2*n][39:16], 64'(2 * (n + 1)));
      if (n >= 3) chk("ramp_out", obs_out[o0+n], 64'(n - 3));
    end
    // second sample 10 cycles after the first is dropped
    o0 = ov_seen; f0 = obs_frm.size();
    send(16'h7777, 5, 10);
    repeat (40) @(posedge clk);
    chk("ovr_pulses", 64'(ov_seen - o0), 1);
    chk("ovr_frames", 64'(obs_frm.size() - f0), 2);
    send(16'h8888, 0, 0);
    chk("ovr_next_addr", obs_frm[f0+2][39:16], 64'(obs_frm[f0][39:16]) + 2);
    // randomized traffic with occasional overruns
    for (int i = 0; i < 25; i++)
      send(16'($urandom), 16'($urandom_range(0, 20)),
           $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 14)) : 0);
    repeat (80) @(posedge clk);
    // pointer wrap
    force dut.wr_ptr = 16'hFFFF;
    @(negedge clk);
    release dut.wr_ptr;
    m_wp = 16'hFFFF;
    f0 = obs_frm.size();
    send(16'hAAAA, 1, 0);
    send(16'hBBBB, 1, 0);
    chk("wrap_wr0", obs_frm[f0][39:16], 24'h01FFFE);
    chk("wrap_wr1", obs_frm[f0+2][39:16], 24'h000000);
    chk("wrap_rd1", obs_frm[f0+3][39:16], 24'h01FFFE);
    chk("wrap_out", obs_out[obs_out.size()-1], 16'hAAAA);
    // reset during the read frame
    repeat (5) @(posedge clk);
    f0 = obs_frm.size(); v0 = outv_cnt;
    @(posedge clk); #1;
    bus.sample_valid = 1; bus.sample_in = 16'hBEEF; bus.delay = 0;
    @(posedge clk); #1 bus.sample_valid = 0;
    k = 0;
    while (obs_frm.size() < f0 + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_rd", k < 200, 1);
    chk("pre_rst_cs", bus.spi_cs, 0);
    #2 nrst = 0;
    #1;
    chk("async_cs", bus.spi_cs, 1);
    chk("async_busy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1 nrst = 1;
    repeat (20) @(posedge clk);
    chk("rst_no_out", 64'(outv_cnt - v0), 0);
    f0 = obs_frm.size();
    send(16'h0042, 0, 0);
    chk("rst_wr_addr", obs_frm[f0][39:16], 0);
    chk("rst_out", obs_out[obs_out.size()-1], 16'h0042);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/sram_delay_sequencer.md
# sram_delay_sequencer

Per-sample transaction sequencer between the codec sample stream and the SPI controller for the external SPI SRAM delay line (23LC1024-class, sequential mode). Each incoming sample triggers two SPI frames: a WRITE of the new sample at the write pointer, then a READ at the write pointer minus the requested delay. The SRAM's returned word is presented as the delayed sample. The block drives the controller's start strobe and transmit word, and consumes its done flag and receive word.

## Interface
- ADDR_W, 16: word-pointer width; SRAM byte address = {ptr, 1'b0}, zero-extended to 24 bits
- DATA_W, 16: sample width
- FRAME_W, 48: SPI frame length = 8 cmd + 24 addr + DATA_W; the controller is built with TX_WIDTH = RX_WIDTH = NSCK = FRAME_W
- clk  in  1  system clock, the only clock
- nrst  in  1  reset; asynchronous, active-low
- sample_valid  in  1  one-cycle strobe: new input sample
- sample_in  in  DATA_W  input sample, qualified by sample_valid
- delay  in  ADDR_W  read offset in samples, sampled on an accepted sample_valid
- sample_out  out  DATA_W  delayed sample, registered; reset 0
- out_valid  out  1  one-cycle pulse when sample_out updates; reset 0
- busy  out  1  high whenever state != IDLE; reset 0
- overrun  out  1  one-cycle pulse when sample_valid is dropped; reset 0
- spi_cs  out  1  controller start line: idle high, a falling edge starts a frame; reset 1
- spi_tx_data  out  FRAME_W  frame to shift out, MSB first; reset 0
- spi_rx_data  in  FRAME_W  controller receive word
- spi_done  in  1  controller idle flag: high = idle, low = frame in progress

## Operation
- States: IDLE, WR_SETUP, WR_START, WR_WAIT, RD_SETUP, RD_START, RD_WAIT, RD_CAPTURE.
- IDLE: on sample_valid, latch sample_in and delay, then go to WR_SETUP.
- WR_SETUP: set spi_tx_data = {8'h02, addr(wr_ptr), sample}, keep spi_cs high, then go to WR_START.
  - The frame is held stable for at least one cycle with spi_cs high so that the controller loads its shift buffer.
- WR_START: drive spi_cs low, clear seen_busy, then go to WR_WAIT.
- WR_WAIT: hold spi_cs low.
  - Set seen_busy when spi_done is low.
  - When seen_busy = 1 and spi_done = 1: spi_cs goes high, wr_ptr <= wr_ptr + 1 (mod 2^ADDR_W), then go to RD_SETUP.
- RD_SETUP: set spi_tx_data = {8'h03, addr(rd_ptr), DATA_W'b0}, with rd_ptr = wr_ptr_old − delay_latched (mod 2^ADDR_W).
  - wr_ptr_old is the address just written, so delay = 0 returns the sample just written.
- RD_START, RD_WAIT: same as the write phase, without the pointer update.
- RD_CAPTURE: entered on completion of RD_WAIT. Wait exactly one cycle, because the controller registers its receive word one cycle after spi_done rises. Then sample_out <= spi_rx_data[DATA_W-1:0], pulse out_valid, and go to IDLE.
- sample_valid in any state other than IDLE: sample dropped, overrun pulses, pointers and the in-flight transaction are unaffected.
- sample_valid in the same cycle that RD_CAPTURE exits: dropped, and overrun pulses.
- wr_ptr wraps from 2^ADDR_W−1 to 0. The subtraction wraps modulo 2^ADDR_W with no saturation.
- Reset asserted mid-frame: all state clears immediately and spi_cs returns high; the abandoned SRAM frame is discarded. wr_ptr resets to 0.
- A change of delay while busy has no effect until the next accepted sample.

## Timing
- Acceptance: sample_valid in IDLE at edge t gives busy = 1 from t+1.
- spi_cs falls two cycles after acceptance.
- Latency from sample_valid to out_valid = 5 + T_wr + T_rd cycles, where T is the number of cycles spi_cs is held low per frame.
  - With the team's SPI controller, T ≤ FRAME_W + 6, so worst-case latency ≤ 2·FRAME_W + 17 = 113 cycles at defaults.
  - The sample period must exceed this; at 48 kHz the margin is large.
- spi_cs is registered and glitch-free.
- spi_tx_data changes only in the *_SETUP states, while spi_cs is high.
- No timeout: if spi_done never falls, the FSM waits indefinitely in *_WAIT.

## Test plan
- Reset check: with nrst low, all outputs hold their reset values (spi_cs = 1, busy = 0, sample_out = 0). Release nrst and apply no stimulus: spi_cs stays high.
- delay = 0, sample_in = 16'h1234 against a behavioural SRAM + controller model:
  - write frame = 48'h02_000000_1234
  - read frame = 48'h03_000000_0000
  - sample_out = 16'h1234 with a single out_valid pulse
- Feed ramp samples 0..9 with delay = 3: from the 4th sample onward sample_out = n−3. Before that, the returned values are the model's preset contents. The write byte address advances by 2 per sample.
- Wrap: preset wr_ptr = 16'hFFFF (write 65535 samples, or force the pointer) and use delay = 1. The next write goes to byte 24'h01FFFE, the following one to 24'h000000. The read after that targets byte 24'h01FFFE.
- Second sample_valid 10 cycles after the first: overrun pulses once, only one write/read pair occurs, and wr_ptr advances by 1.
- Assert nrst low during RD_WAIT: spi_cs goes high in the same cycle (asynchronous), busy = 0, and out_valid never pulses. After release, the next sample writes to address 0.
